// File: rtl/mmbuf_sched.sv
// mmbuf_sched: two-lane in-order memory request scheduler.
// Lane0/lane1 requests are buffered in program order in a circular FIFO and
// handed to the LSU one per cycle. CSR requests (para[top:top-1]==2'b11) wait
// one cycle after any preceding pop so their side effects stay serialised.
// Optional macro MMBUF_BYPASS_EN: empty-FIFO lane0 non-CSR request is forwarded
// combinationally to the LSU (0-cycle latency).
module mmbuf_sched #(
  parameter int DEPTH    = 8,
  parameter int PARA_LEN = 11,
  parameter int XLEN     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in0_vld,
  input  logic [PARA_LEN-1:0]        in0_para,
  input  logic [XLEN-1:0]            in0_addr,
  input  logic [XLEN-1:0]            in0_wdata,
  input  logic                       in1_vld,
  input  logic [PARA_LEN-1:0]        in1_para,
  input  logic [XLEN-1:0]            in1_addr,
  input  logic [XLEN-1:0]            in1_wdata,
  output logic                       in_rdy,
  output logic                       out_vld,
  output logic [PARA_LEN-1:0]        out_para,
  output logic [XLEN-1:0]            out_addr,
  output logic [XLEN-1:0]            out_wdata,
  input  logic                       out_rdy,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       csr_wait
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [PARA_LEN-1:0] para;
    logic [XLEN-1:0]     addr;
    logic [XLEN-1:0]     wdata;
  } req_t;

  req_t          mem_q [DEPTH];
  req_t          mem_d [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic          last_pop_q, last_pop_d;

  req_t          lane0, lane1, head;
  logic          empty, head_csr, hold, fifo_vld, byp, hs, pop_fifo;
  logic          acc, w0, w1;
  logic [PW-1:0] free_cnt;

  assign lane0 = {in0_para, in0_addr, in0_wdata};
  assign lane1 = {in1_para, in1_addr, in1_wdata};

  // Occupancy falls out of the extra-MSB pointers; modular subtraction covers wrap.
  assign count    = wp_q - rp_q;
  assign empty    = (wp_q == rp_q);
  assign free_cnt = PW'(DEPTH) - count;
  assign in_rdy   = (free_cnt >= PW'(2));

  assign head     = mem_q[rp_q[AW-1:0]];
  assign head_csr = (head.para[PARA_LEN-1 -: 2] == 2'b11);
  assign hold     = head_csr & last_pop_q;
  assign fifo_vld = ~empty & ~hold;
  assign csr_wait = ~empty & hold;

`ifdef MMBUF_BYPASS_EN
  logic in0_csr;
  assign in0_csr = (in0_para[PARA_LEN-1 -: 2] == 2'b11);
  assign byp     = empty & ~flush & in0_vld & ~in1_vld & ~in0_csr;
`else
  assign byp     = 1'b0;
`endif

  // Output mux: bypassed lane0 when forwarding, otherwise the registered head.
  always_comb begin
    out_vld   = fifo_vld;
    out_para  = head.para;
    out_addr  = head.addr;
    out_wdata = head.wdata;
    if (byp) begin
      out_vld   = 1'b1;
      out_para  = lane0.para;
      out_addr  = lane0.addr;
      out_wdata = lane0.wdata;
    end
  end

  assign hs       = out_vld & out_rdy;
  assign pop_fifo = fifo_vld & out_rdy;
  // Both lanes accepted together or not at all; a bypass taken by the LSU skips storage.
  assign acc      = in_rdy & ~flush;
  assign w0       = acc & in0_vld & ~(byp & out_rdy);
  assign w1       = acc & in1_vld;

  // Next-state: flush wins over push; lane1 lands behind lane0 when both write.
  always_comb begin
    mem_d      = mem_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    last_pop_d = hs;
    if (flush) begin
      wp_d       = '0;
      rp_d       = '0;
      last_pop_d = 1'b0;
    end else begin
      if (w0) mem_d[wp_q[AW-1:0]] = lane0;
      if (w1) mem_d[w0 ? AW'(wp_q + PW'(1)) : wp_q[AW-1:0]] = lane1;
      wp_d = wp_q + PW'(w0) + PW'(w1);
      if (pop_fifo) rp_d = rp_q + PW'(1);
    end
  end

  // State registers; storage cleared so the head reads 0 out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      last_pop_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      last_pop_q <= last_pop_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: doc/mmbuf_sched.md
Name: mmbuf_sched

Overview:
- Two-lane in-order scheduler for the memory-request outputs of the superscalar ALU lanes.
- Each lane's ALU presents at most one request per cycle as vld/para/addr/wdata.
- The block buffers requests in program order (lane0 before lane1) in a circular FIFO and hands them one per cycle to the LSU over a valid/ready handshake.
- Each CSR request (para top bits 2'b11) issues only once every earlier request has been accepted, which serialises CSR side effects.

Parameters:
- DEPTH, 8: FIFO entries; power of two, minimum 4.
- PARA_LEN, 11: width of the para field; equals `MMBUF_PARA_LEN.
- XLEN, 32: address and data width; equals `XLEN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of all buffered requests (branch redirect).
- in0_vld  in  1  lane0 request valid.
- in0_para  in  PARA_LEN  lane0 request para.
- in0_addr  in  XLEN  lane0 request address.
- in0_wdata  in  XLEN  lane0 request write data.
- in1_vld, in1_para, in1_addr, in1_wdata  in  same widths  lane1 request; lane1 is younger than lane0.
- in_rdy  out  1  high when at least 2 entries are free; both lanes are accepted or neither.
- out_vld  out  1  head request valid to the LSU.
- out_para  out  PARA_LEN  head request para.
- out_addr  out  XLEN  head request address.
- out_wdata  out  XLEN  head request write data.
- out_rdy  in  1  LSU accepts the head this cycle.
- count  out  log2(DEPTH)+1  number of occupied entries.
- csr_wait  out  1  head is a CSR request held back by the serialisation rule.

Behaviour:
- Reset (rst=0, asynchronous): write pointer, read pointer and count go to 0. Outputs out_vld=0, csr_wait=0, count=0, in_rdy=1. Entry contents are don't-care; out_para, out_addr and out_wdata read 0 after reset.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full means the index bits are equal and the MSBs differ; empty means the pointers are equal.
- Push happens at the clock edge when in_rdy=1:
  - in0_vld&in1_vld: lane0 goes to wp and lane1 to wp+1; wp advances by 2.
  - Exactly one of the two valid: that lane goes to wp; wp advances by 1.
  - in1_vld without in0_vld is legal and pushes lane1 alone.
  - in_rdy=0: inputs are ignored. The upstream stall logic holds them; no error is flagged.
- in_rdy is combinational from count: in_rdy = (DEPTH - count) >= 2. It does not depend on out_rdy in the same cycle.
- Pop:
  - out_vld = non-empty & ~hold.
  - Pop occurs when out_vld & out_rdy; rp advances by 1.
  - out_para, out_addr and out_wdata come from registered FIFO storage at rp. The head presented in a given cycle is the entry at rp at the start of that cycle.
- CSR serialisation: entry type CSR means para[PARA_LEN-1:PARA_LEN-2]==2'b11.
  - A pop event asserts a 1-cycle registered flag, last_pop.
  - hold = head is CSR & last_pop. A CSR head therefore waits one cycle after the preceding pop, so the LSU has sampled the prior request before the CSR issues.
  - csr_wait = non-empty & hold.
  - A CSR head arriving into an empty FIFO does not wait.
- Simultaneous push and pop: legal. count = count + pushes - pop. A full FIFO with a pop still reports in_rdy from the pre-pop count, so the status is conservative.
- Only lane0, or only lane1, pushing CSR pairs: ordering is always strictly lane0 before lane1 within a cycle and older cycle before younger cycle.
- flush:
  - Next cycle: rp=wp=0, count=0, last_pop=0.
  - Pushes in the flush cycle are dropped.
  - A pop in the flush cycle still completes at the LSU, which owns that handshake. flush has priority over push in pointer update.
- Latency: a request pushed at edge N is visible on out_* in cycle N+1 at the earliest.

Optional Feature:
- Macro: MMBUF_BYPASS_EN.
- Defined:
  - When the FIFO is empty, flush=0, in0_vld=1, in1_vld=0 and in0_para is not CSR, the out_* signals are driven combinationally from lane0, giving 0-cycle latency.
  - If out_rdy=1 in that case, the request is not written into the FIFO.
  - If out_rdy=0, it is pushed normally.
  - out_vld becomes combinational from in0_vld in that case.
- Undefined: all requests pass through the FIFO. Minimum latency is 1 cycle and all outputs are registered.

Test Plan:
- Reset then idle -> out_vld=0, count=0, in_rdy=1, csr_wait=0. Assert rst=0 mid-traffic with count=5 -> count=0 and out_vld=0 immediately, without waiting for clk.
- Dual push with in0 addr=0x100 and in1 addr=0x104, out_rdy=1 -> out_addr is 0x100 in cycle N+1 and 0x104 in cycle N+2; count follows 2, 1, 0.
- out_rdy=0 with dual pushes for 4 cycles (DEPTH=8) -> count reaches 8 and in_rdy drops at count=7. A push offered at count=7 is ignored. Then out_rdy=1 drains entries in push order 0..7 across the pointer wrap.
- Load with para=0x0A2 followed by CSR with para=0x6C1 (top bits 11), out_rdy=1 -> load pops in cycle N+1, CSR shows csr_wait=1 in N+2 and pops in N+3.
- flush with count=6 while lane pushes are offered -> next cycle count=0 and out_vld=0. The following push of addr=0x200 is the next head.
- MMBUF_BYPASS_EN with empty FIFO, in0_vld=1, addr=0x300, out_rdy=1 -> out_vld=1 and out_addr=0x300 in the same cycle, count stays 0. Repeat with out_rdy=0 -> count=1 next cycle.
